// File: rtl/mem_load_resp_queue.sv
// In-order load response queue: DEPTH outstanding loads, aligned/extended results to WB via valid/ready.
// Data_ok -> resp_valid in 1 cycle (0 with MEM_RESP_BYPASS_EN); req_ready drops at DEPTH outstanding, flushed beats are discarded.
module mem_load_resp_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_push,
   output logic             req_ready,
   input  logic [2:0]       req_ld_op,
   input  logic [1:0]       req_addr_lo,
   input  logic [TAG_W-1:0] req_dest,
   input  logic             data_sram_data_ok,
   input  logic [31:0]      data_sram_rdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_result,
   output logic [TAG_W-1:0] resp_dest,
   output logic [CNT_W-1:0] outstanding,
   output logic             discard_pending
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {SLOT_EMPTY, SLOT_WAIT, SLOT_READY} slot_st_e;

   slot_st_e         st_q   [DEPTH];
   slot_st_e         st_d   [DEPTH];
   logic [2:0]       op_q   [DEPTH];
   logic [2:0]       op_d   [DEPTH];
   logic [1:0]       lo_q   [DEPTH];
   logic [1:0]       lo_d   [DEPTH];
   logic [TAG_W-1:0] dest_q [DEPTH];
   logic [TAG_W-1:0] dest_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [CNT_W-1:0] count_q, count_d, discard_q, discard_d;
   logic [CNT_W-1:0] n_wait, flush_sum;
   logic             head_wait, head_ready, bypass, pop;

   function automatic logic [31:0] align(input logic [31:0] d, input logic [2:0] op,
                                         input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> {lo, 3'b000});
      h = 16'(d >> {lo[1], 4'b0000});
      case (op)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {24'h0, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b011:  return {16'h0, h};
         default: return d;
      endcase
   endfunction

   always_comb begin
      n_wait = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (st_q[i] == SLOT_WAIT) n_wait = n_wait + CNT_W'(1);
      end
   end

   assign head_wait  = (st_q[head_q] == SLOT_WAIT);
   assign head_ready = (st_q[head_q] == SLOT_READY);

`ifdef MEM_RESP_BYPASS_EN
   // A WAIT head is always the fill slot, so the beat can be forwarded straight out.
   assign bypass = data_sram_data_ok && (discard_q == '0) && head_wait;
`else
   assign bypass = 1'b0;
`endif

   assign resp_valid      = !flush && (head_ready || bypass);
   assign resp_result     = resp_valid ? align(bypass ? data_sram_rdata : data_q[head_q],
                                               op_q[head_q], lo_q[head_q]) : 32'h0;
   assign resp_dest       = resp_valid ? dest_q[head_q] : '0;
   assign outstanding     = count_q + discard_q;
   assign req_ready       = (outstanding < CNT_W'(DEPTH));
   assign discard_pending = (discard_q != '0);
   assign pop             = resp_valid && resp_ready;
   assign flush_sum       = discard_q + n_wait + CNT_W'(req_push);

   always_comb begin
      st_d      = st_q;
      op_d      = op_q;
      lo_d      = lo_q;
      dest_d    = dest_q;
      data_d    = data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      fill_d    = fill_q;
      count_d   = count_q;
      discard_d = discard_q;

      if (flush) begin
         // Every load still waiting for its beat, plus a same-cycle push, becomes a discard.
         for (int i = 0; i < DEPTH; i++) st_d[i] = SLOT_EMPTY;
         head_d    = '0;
         tail_d    = '0;
         fill_d    = '0;
         count_d   = '0;
         discard_d = (data_sram_data_ok && flush_sum != '0) ? flush_sum - CNT_W'(1) : flush_sum;
      end else begin
         if (pop) begin
            st_d[head_q] = SLOT_EMPTY;
            head_d       = head_q + PTR_W'(1);
         end
         if (req_push) begin
            st_d[tail_q]   = SLOT_WAIT;
            op_d[tail_q]   = req_ld_op;
            lo_d[tail_q]   = req_addr_lo;
            dest_d[tail_q] = req_dest;
            tail_d         = tail_q + PTR_W'(1);
         end
         if (data_sram_data_ok) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CNT_W'(1);
            end else if (st_q[fill_q] == SLOT_WAIT) begin
               fill_d = fill_q + PTR_W'(1);
               if (!(bypass && resp_ready)) begin
                  st_d[fill_q]   = SLOT_READY;
                  data_d[fill_q] = data_sram_rdata;
               end
            end
         end
         count_d = count_q + CNT_W'(req_push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]   <= SLOT_EMPTY;
            op_q[i]   <= '0;
            lo_q[i]   <= '0;
            dest_q[i] <= '0;
            data_q[i] <= '0;
         end
         head_q    <= '0;
         tail_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
         discard_q <= '0;
      end else begin
         st_q      <= st_d;
         op_q      <= op_d;
         lo_q      <= lo_d;
         dest_q    <= dest_d;
         data_q    <= data_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
         discard_q <= discard_d;
      end
   end
endmodule

// File: tb/tb_mem_load_resp_queue.sv
// Scoreboard bench for mem_load_resp_queue (DEPTH=4, TAG_W=5); follows MEM_RESP_BYPASS_EN if defined.
module tb_mem_load_resp_queue;
   logic        clk = 1'b0;
   logic        reset, flush, req_push, req_ready;
   logic [2:0]  req_ld_op;
   logic [1:0]  req_addr_lo;
   logic [4:0]  req_dest;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_dest;
   logic [2:0]  outstanding;
   logic        discard_pending;

   typedef struct {logic [2:0] op; logic [1:0] lo; logic [4:0] dest;} req_t;
   typedef struct {logic [31:0] res; logic [4:0] dest;} exp_t;

   req_t        req_q[$];
   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   int          md = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   mem_load_resp_queue #(.DEPTH(4), .TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush), .req_push(req_push), .req_ready(req_ready),
      .req_ld_op(req_ld_op), .req_addr_lo(req_addr_lo), .req_dest(req_dest),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .resp_dest(resp_dest), .outstanding(outstanding), .discard_pending(discard_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_align(input logic [31:0] d, input logic [2:0] op,
                                               input logic [1:0] lo);
      logic [31:0] s8, s16;
      s8  = d >> (lo * 8);
      s16 = lo[1] ? (d >> 16) : d;
      case (op)
         3'd0:    return s8[7]   ? {24'hFFFFFF, s8[7:0]} : {24'h0, s8[7:0]};
         3'd1:    return {24'h0, s8[7:0]};
         3'd2:    return s16[15] ? {16'hFFFF, s16[15:0]} : {16'h0, s16[15:0]};
         3'd3:    return {16'h0, s16[15:0]};
         default: return d;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_result", resp_result, e.res);
            check("sb_dest", 32'(resp_dest), 32'(e.dest));
         end
         obs_q.push_back(resp_result);
      end
   end

   task automatic drive(input logic push, input logic [2:0] op, input logic [1:0] lo,
                        input logic [4:0] dest, input logic dok, input logic [31:0] rd,
                        input logic rr, input logic fl);
      int mo;
      mo = req_q.size() + exp_q.size() + md;
      check("outstanding", 32'(outstanding), 32'(mo));
      check("req_ready", 32'(req_ready), 32'(mo < 4));
      check("discard_pending", 32'(discard_pending), 32'(md != 0));
      req_push = push; req_ld_op = op; req_addr_lo = lo; req_dest = dest;
      data_sram_data_ok = dok; data_sram_rdata = rd; resp_ready = rr; flush = fl;
      if (fl) begin
         md = md + req_q.size() + int'(push);
         if (dok && md > 0) md--;
         req_q.delete();
         exp_q.delete();
      end else begin
         if (push) req_q.push_back('{op, lo, dest});
         if (dok) begin
            if (md > 0) md--;
            else if (req_q.size() != 0) begin
               req_t r;
               r = req_q.pop_front();
               exp_q.push_back('{model_align(rd, r.op, r.lo), r.dest});
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic push, input logic [2:0] op, input logic [1:0] lo,
                       input logic [4:0] dest, input logic dok, input logic [31:0] rd,
                       input logic rr, input logic fl);
      drive(push, op, lo, dest, dok, rd, rr, fl);
      tick();
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, rr, 1'b0);
   endtask

   function automatic logic [31:0] obs_pop();
      if (obs_q.size() == 0) return 32'hDEADDEAD;
      return obs_q.pop_front();
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: bench exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int ob;
      reset = 1'b1; flush = 1'b0; req_push = 1'b0; req_ld_op = '0; req_addr_lo = '0;
      req_dest = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_result", resp_result, 32'h0);
      check("rst_dest", 32'(resp_dest), 32'd0);
      check("rst_outstanding", 32'(outstanding), 32'd0);
      check("rst_discard", 32'(discard_pending), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;

      // Sign-extended byte and its latency
      step(1'b1, 3'd0, 2'd3, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h80AA5511, 1'b0, 1'b0);
      #1;
`ifdef MEM_RESP_BYPASS_EN
      check("t1_latency", 32'(resp_valid), 32'd1);
`else
      check("t1_latency", 32'(resp_valid), 32'd0);
`endif
      tick();
      check("t1_valid", 32'(resp_valid), 32'd1);
      check("t1_result", resp_result, 32'hFFFFFF80);
      check("t1_dest", 32'(resp_dest), 32'd7);
      idle(1'b1);
      idle(1'b1);
      check("t1_invalid_result", resp_result, 32'h0);
      obs_q.delete();

      // ld.hu then ld.w in order
      step(1'b1, 3'd3, 2'd2, 5'd3, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 3'd4, 2'd0, 5'd4, 1'b1, 32'hBEEF1234, 1'b1, 1'b0);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h12345678, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("t2_first", obs_pop(), 32'h0000BEEF);
      check("t2_second", obs_pop(), 32'h12345678);

      // Full queue backpressure
      for (int i = 0; i < 4; i++) step(1'b1, 3'd4, 2'd0, 5'(i), 1'b0, 32'h0, 1'b1, 1'b0);
      idle(1'b1);
      check("t3_full_ready", 32'(req_ready), 32'd0);
      check("t3_full_outstanding", 32'(outstanding), 32'd4);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hA0A0A0A0, 1'b1, 1'b0);
      idle(1'b1);
      check("t3_ready_again", 32'(req_ready), 32'd1);
      check("t3_outstanding", 32'(outstanding), 32'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Flush with in-flight beats and a same-cycle push
      for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 2'd0, 5'(i + 8), 1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 3'd4, 2'd0, 5'd11, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      check("t4_flush_valid", 32'(resp_valid), 32'd0);
      tick();
      check("t4_discard_outstanding", 32'(outstanding), 32'd4);
      check("t4_discard_pending", 32'(discard_pending), 32'd1);
      ob = obs_q.size();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hDEAD0000 + 32'(i), 1'b1, 1'b0);
         #1;
         check("t4_dropped_valid", 32'(resp_valid), 32'd0);
         tick();
      end
      check("t4_drained", 32'(outstanding), 32'd0);
      step(1'b1, 3'd4, 2'd0, 5'd12, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("t4_obs_count", 32'(obs_q.size()), 32'(ob + 1));
      check("t4_post_flush", obs_q[obs_q.size() - 1], 32'hCAFEF00D);
      obs_q.delete();

      // Flush while head is READY and WB is ready
      step(1'b1, 3'd4, 2'd0, 5'd10, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 3'd4, 2'd0, 5'd11, 1'b1, 32'h11112222, 1'b0, 1'b0);
      idle(1'b0);
      check("t5_head_ready", 32'(resp_valid), 32'd1);
      drive(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      check("t5_flush_valid", 32'(resp_valid), 32'd0);
      tick();
      check("t5_outstanding", 32'(outstanding), 32'd1);
      check("t5_no_pop", 32'(obs_q.size()), 32'd0);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h33334444, 1'b1, 1'b0);
      idle(1'b1);
      check("t5_drained", 32'(outstanding), 32'd0);

      // Four READY entries held, then drained back to back
      step(1'b1, 3'd2, 2'd0, 5'd20, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 3'd1, 2'd2, 5'd21, 1'b1, 32'h00008001, 1'b0, 1'b0);
      step(1'b1, 3'd3, 2'd2, 5'd22, 1'b1, 32'h00AB0000, 1'b0, 1'b0);
      step(1'b1, 3'd7, 2'd1, 5'd23, 1'b1, 32'hFFFF0000, 1'b0, 1'b0);
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h13579BDF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         check("t6_hold_result", resp_result, 32'hFFFF8001);
         check("t6_hold_dest", 32'(resp_dest), 32'd20);
      end
      check("t6_full", 32'(req_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
         #1;
         check("t6_b2b_valid", 32'(resp_valid), 32'd1);
         tick();
      end
      idle(1'b1);
      check("t6_r0", obs_pop(), 32'hFFFF8001);
      check("t6_r1", obs_pop(), 32'h000000AB);
      check("t6_r2", obs_pop(), 32'h0000FFFF);
      check("t6_r3", obs_pop(), 32'h13579BDF);
      check("t6_empty_valid", 32'(resp_valid), 32'd0);

      // Reset in the middle of traffic
      step(1'b1, 3'd4, 2'd0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 3'd4, 2'd0, 5'd2, 1'b1, 32'h55555555, 1'b0, 1'b0);
      req_push = 1'b0; data_sram_data_ok = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      req_q.delete(); exp_q.delete(); md = 0;
      check("t7_outstanding", 32'(outstanding), 32'd0);
      check("t7_valid", 32'(resp_valid), 32'd0);
      check("t7_req_ready", 32'(req_ready), 32'd1);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
